uart_send: RTL and testbench

Byte-serial UART transmitter: the transmit-side counterpart of the receive path and its `uart_en` strobe. It waits for a rising edge on `uart_en` and captures `uart_din` on that edge. It then drives one 8N1 frame on `uart_txd`, LSB first, at `UART_BPS`. It sits between the FIR result/loopback logic and the board TX pin, and reports `tx_busy` so upstream logic knows when the next byte can be issued.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_edge_det.sv | 25 ++
 rtl/uart_send.sv | 88 ++++++++
 tb/tb_uart_send.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and helpers.
// Frame length follows UART_TX_PARITY_EN (even parity after bit 7).
package uart_pkg;

    localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_e;

    function automatic int bps_cnt(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_edge_det.sv
// Two-flop synchroniser with a rising-edge pulse.
// Shared by the transmit request and the receive-side indicators.
module uart_edge_det (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic sig_in,
    output logic sig_rise
);

    logic sig_d0;
    logic sig_d1;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sig_d0 <= 1'b0;
            sig_d1 <= 1'b0;
        end else begin
            sig_d0 <= sig_in;
            sig_d1 <= sig_d0;
        end
    end

    assign sig_rise = sig_d0 & ~sig_d1;

endmodule

// File: rtl/uart_send.sv
// Byte-serial UART transmitter, 8N1 LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit after bit 7.
module uart_send
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_en,
    input  logic [7:0] uart_din,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       tx_drop
);

    localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
    localparam int CW      = $clog2(BPS_CNT);
    localparam int FW      = $clog2(FRAME_BITS);

    localparam logic [CW-1:0] CNT_MAX  = CW'(BPS_CNT - 1);
    localparam logic [FW-1:0] LAST_BIT = FW'(FRAME_BITS - 1);

    tx_state_e       state;
    logic            en_req;
    logic [7:0]      tx_data;
    logic [CW-1:0]   clk_cnt;
    logic [FW-1:0]   tx_cnt;
    logic [FRAME_BITS-1:0] frame;

    uart_edge_det u_en_det (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .sig_in  (uart_en),
        .sig_rise(en_req)
    );

`ifdef UART_TX_PARITY_EN
    assign frame = {STOP_BIT, ^tx_data, tx_data, START_BIT};
`else
    assign frame = {STOP_BIT, tx_data, START_BIT};
`endif

    assign tx_busy = (state == TX_SEND);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state    <= TX_IDLE;
            uart_txd <= STOP_BIT;
            tx_drop  <= 1'b0;
            tx_data  <= '0;
            clk_cnt  <= '0;
            tx_cnt   <= '0;
        end else begin
            // Requests are never queued; one arriving mid-frame is flagged.
            tx_drop <= en_req & (state == TX_SEND);
            unique case (state)
                TX_IDLE: begin
                    uart_txd <= STOP_BIT;
                    if (en_req) begin
                        tx_data <= uart_din;
                        clk_cnt <= '0;
                        tx_cnt  <= '0;
                        state   <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (clk_cnt == '0)
                        uart_txd <= frame[tx_cnt];
                    if (clk_cnt == CNT_MAX) begin
                        clk_cnt <= '0;
                        if (tx_cnt == LAST_BIT) begin
                            tx_cnt <= '0;
                            state  <= TX_IDLE;
                        end else begin
                            tx_cnt <= tx_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_send.sv
// Self-checking bench for uart_send at BPS_CNT=10.
// Build with UART_TX_PARITY_EN to exercise the parity frame.
module tb_uart_send;

    localparam int BPS = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       sys_clk;
    logic       sys_rst;
    logic       uart_en;
    logic [7:0] uart_din;
    logic       uart_txd;
    logic       tx_busy;
    logic       tx_drop;

    int checks;
    int failures;
    int drop_cnt;

    uart_send #(
        .CLK_FREQ(1000),
        .UART_BPS(100)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .uart_en (uart_en),
        .uart_din(uart_din),
        .uart_txd(uart_txd),
        .tx_busy (tx_busy),
        .tx_drop (tx_drop)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk)
        if (tx_drop === 1'b1)
            drop_cnt++;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference line value for frame position j of byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int j);
        if (j == 0)
            return 1'b0;
        if (j <= 8)
            return b[j-1];
`ifdef UART_TX_PARITY_EN
        if (j == 9)
            return ^b;
`endif
        return 1'b1;
    endfunction

    // Called right at a negedge; raises uart_en so the next posedge is k.
    task automatic send_frame(input logic [7:0] b, input bit hold);
        int busy_len;
        int bad;
        uart_din = b;
        uart_en  = 1'b1;
        @(negedge sys_clk);
        check("busy_before_k1", tx_busy, 0);
        @(negedge sys_clk);
        check("busy_at_k1", tx_busy, 1);
        check("txd_at_k1", uart_txd, 1);
        if (!hold)
            uart_en = 1'b0;
        busy_len = 1;
        for (int j = 0; j < NB; j++) begin
            bad = 0;
            for (int c = 0; c < BPS; c++) begin
                @(negedge sys_clk);
                if (tx_busy === 1'b1)
                    busy_len++;
                if (uart_txd !== exp_bit(b, j))
                    bad++;
            end
            check($sformatf("byte%02h_bit%0d_bad_cycles", b, j), bad, 0);
        end
        check("busy_len", busy_len, NB * BPS);
        check("busy_fall", tx_busy, 0);
        check("txd_after", uart_txd, 1);
    endtask

    initial begin
        int d0;
        logic [7:0] rb;
        checks   = 0;
        failures = 0;
        drop_cnt = 0;
        sys_rst  = 1'b0;
        uart_en  = 1'b0;
        uart_din = 8'h00;
        repeat (3) @(negedge sys_clk);
        check("rst_txd", uart_txd, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_drop", tx_drop, 0);
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);

        send_frame(8'hA5, 1'b0);
        repeat (3) @(negedge sys_clk);

        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            send_frame(rb, 1'b0);
            repeat (2 + $urandom_range(0, 4)) @(negedge sys_clk);
        end

        // Second rise 50 cycles in is dropped; a rise at 104 is accepted.
        d0 = drop_cnt;
        fork
            send_frame(8'h5A, 1'b0);
            begin
                repeat (50) @(negedge sys_clk);
                uart_din = 8'hC3;
                uart_en  = 1'b1;
                repeat (3) @(negedge sys_clk);
                uart_en  = 1'b0;
                uart_din = 8'h5A;
            end
        join
        check("drop_once", drop_cnt - d0, 1);
        repeat (2) @(negedge sys_clk);
        d0 = drop_cnt;
        send_frame(8'h96, 1'b0);
        check("drop_none_at_104", drop_cnt - d0, 0);

        // Held-high enable: one frame only, no drops.
        repeat (3) @(negedge sys_clk);
        d0 = drop_cnt;
        send_frame(8'h3C, 1'b1);
        repeat (200) @(negedge sys_clk);
        check("hold_busy_low", tx_busy, 0);
        check("hold_txd_high", uart_txd, 1);
        check("hold_no_drop", drop_cnt - d0, 0);
        uart_en = 1'b0;
        repeat (3) @(negedge sys_clk);

        // Reset in the middle of a 0xFF frame.
        uart_din = 8'hFF;
        uart_en  = 1'b1;
        repeat (2) @(negedge sys_clk);
        uart_en = 1'b0;
        repeat (43) @(negedge sys_clk);
        check("mid_busy", tx_busy, 1);
        sys_rst = 1'b0;
        #1;
        check("abort_txd", uart_txd, 1);
        check("abort_busy", tx_busy, 0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        check("post_rst_busy", tx_busy, 0);
        send_frame(8'h01, 1'b0);

        repeat (2) @(negedge sys_clk);
        send_frame(8'h07, 1'b0);

        repeat (5) @(negedge sys_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
